// File: rtl/note_sequencer.sv
// Melody sequencer: steps a (note, duration) table and drives the tone generator's note select.
// Optional NOTE_GAP_EN inserts GAP_T ena ticks of silence after every note.
module note_sequencer #(
    parameter int DEPTH = 16,
    parameter int DUR_W = 16,
    parameter int GAP_T = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [2:0]               wr_note,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic [2:0]               f_ent,
    output logic                     playing,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] cur_idx
);

    localparam int AW    = $clog2(DEPTH);
    localparam int GAP_W = $clog2(GAP_T + 1);
    // One down-counter times both notes and gaps, so it must hold either load value.
    localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         note_mem [DEPTH];
    logic [DUR_W-1:0]   dur_mem  [DEPTH];
    logic [2:0]         rd_note;
    logic [DUR_W-1:0]   rd_dur;

    // Table storage is not reset; a write in the fetch cycle lands after the read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            note_mem[wr_addr] <= wr_note;
            dur_mem[wr_addr]  <= wr_dur;
        end
    end

    assign rd_note = note_mem[cur_idx];
    assign rd_dur  = dur_mem[cur_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            cur_idx <= '0;
            f_ent   <= '0;
            playing <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= S_IDLE;
                f_ent   <= '0;
                playing <= 1'b0;
            end else if (start) begin
                state   <= S_FETCH;
                cur_idx <= '0;
                playing <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        f_ent <= '0;
                    end
                    S_FETCH: begin
                        if (rd_dur == '0) begin
                            if (loop) begin
                                cur_idx <= '0;
                            end else begin
                                state   <= S_IDLE;
                                f_ent   <= '0;
                                playing <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            f_ent <= rd_note;
                            cnt   <= CNT_W'(rd_dur);
                            state <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (ena) begin
                            if (cnt == CNT_W'(1)) begin
`ifdef NOTE_GAP_EN
                                state <= S_GAP;
                                f_ent <= '0;
                                cnt   <= CNT_W'(GAP_T);
`else
                                state   <= S_FETCH;
                                cur_idx <= cur_idx + AW'(1);
`endif
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
`ifdef NOTE_GAP_EN
                    S_GAP: begin
                        if (ena) begin
                            if (cnt == CNT_W'(1)) begin
                                state   <= S_FETCH;
                                cur_idx <= cur_idx + AW'(1);
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
`endif
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer against a cycle-level behavioural melody model.
module tb_note_sequencer;

    localparam int DEPTH = 16;
    localparam int DUR_W = 16;
    localparam int AW    = 4;
    localparam int GAP_T = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [2:0]       wr_note;
    logic [DUR_W-1:0] wr_dur;
    logic             start;
    logic             stop;
    logic             loop;
    logic [2:0]       f_ent;
    logic             playing;
    logic             done;
    logic [AW-1:0]    cur_idx;

    note_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .GAP_T(GAP_T)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_note(wr_note), .wr_dur(wr_dur), .start(start), .stop(stop), .loop(loop),
        .f_ent(f_ent), .playing(playing), .done(done), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int ena_mode = 0;
    int done_seen = 0;

    // Reference: melody table plus "where in the melody are we" bookkeeping.
    int tnote [DEPTH];
    int tdur  [DEPTH];
    bit m_active, m_fetch, m_done;
    int m_idx, m_left, m_gap, m_note;

    task automatic model_reset();
        m_active = 0; m_fetch = 0; m_done = 0;
        m_idx = 0; m_left = 0; m_gap = 0; m_note = 0;
    endtask

    task automatic model_clock();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_done = 0;
            if (stop) begin
                m_active = 0; m_fetch = 0; m_gap = 0; m_note = 0;
            end else if (start) begin
                m_active = 1; m_fetch = 1; m_gap = 0; m_idx = 0;
            end else if (!m_active) begin
                m_note = 0;
            end else if (m_fetch) begin
                if (tdur[m_idx] == 0) begin
                    if (loop) m_idx = 0;
                    else begin
                        m_active = 0; m_fetch = 0; m_done = 1; m_note = 0;
                    end
                end else begin
                    m_note = tnote[m_idx]; m_left = tdur[m_idx]; m_fetch = 0;
                end
            end else if (ena) begin
                if (m_gap > 0) begin
                    if (m_gap == 1) begin
                        m_gap = 0; m_fetch = 1; m_idx = (m_idx + 1) % DEPTH;
                    end else m_gap--;
                end else if (m_left > 1) begin
                    m_left--;
                end else begin
`ifdef NOTE_GAP_EN
                    m_gap = GAP_T; m_note = 0;
`else
                    m_fetch = 1; m_idx = (m_idx + 1) % DEPTH;
`endif
                end
            end
        end
        if (wr_en) begin
            tnote[wr_addr] = int'(wr_note);
            tdur[wr_addr]  = int'(wr_dur);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("f_ent", 32'(f_ent), 32'(m_note));
        chk("playing", 32'(playing), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        chk("cur_idx", 32'(cur_idx), 32'(m_idx));
        if (done === 1'b1) done_seen++;
    endtask

    task automatic step();
        if (ena_mode == 0) ena = (cyc_n % 4 == 0);
        else ena = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_clock();
        cyc_n++;
        #1;
        check_outputs();
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int a, input int n, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_note = 3'(n); wr_dur = DUR_W'(d);
        step();
    endtask

    task automatic wait_idx(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (!(cur_idx === AW'(target) && playing === 1'b1) && k < budget) begin
            step();
            k++;
        end
        vectors++;
        assert (k < budget) else begin
            miscompares++;
            $error("FAIL %s timeout observed_idx=%0d expected_idx=%0d", tag, cur_idx, target);
        end
    endtask

    initial begin
        int newnote;
        rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_note = '0; wr_dur = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin tnote[i] = 0; tdur[i] = 0; end
        model_reset();

        // Reset values
        run(3);
        chk("rst_f_ent", 32'(f_ent), 0);
        chk("rst_playing", 32'(playing), 0);
        rst_n = 1'b1;
        run(2);

        // Melody {1,3},{2,2},{0,4},{5,0}, filler entries
        wr(0, 1, 3); wr(1, 2, 2); wr(2, 0, 4); wr(3, 5, 0);
        for (int i = 4; i < DEPTH; i++) wr(i, 3, 1);
        ena_mode = 0;
        done_seen = 0;
        start = 1'b1;
        run(70);
        chk("single_pass_done_count", 32'(done_seen), 1);
        chk("single_pass_idle", 32'(playing), 0);

        // Looping: no done while loop is held, then exactly one after dropping it
        loop = 1'b1;
        done_seen = 0;
        start = 1'b1;
        run(130);
        chk("loop_done_count", 32'(done_seen), 0);
        loop = 1'b0;
        run(70);
        chk("unloop_done_count", 32'(done_seen), 1);

        // Stop in entry 1
        done_seen = 0;
        start = 1'b1;
        wait_idx(1, 100, "wait_entry1");
        run(2);
        stop = 1'b1;
        step();
        chk("stop_f_ent", 32'(f_ent), 0);
        chk("stop_playing", 32'(playing), 0);
        run(10);
        chk("stop_done_count", 32'(done_seen), 0);

        // start and stop together from IDLE
        start = 1'b1; stop = 1'b1;
        step();
        chk("start_stop_playing", 32'(playing), 0);
        run(3);

        // Full table, no marker: wrap 15 -> 0 and rewrite entry 0 while 15 plays
        ena_mode = 1;
        for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
        start = 1'b1;
        wait_idx(15, 600, "wait_entry15");
        newnote = (tnote[0] + 1) % 8;
        wr(0, newnote, 2);
        wait_idx(0, 100, "wait_wrap0");
        step();
        chk("wrap_new_note", 32'(f_ent), 32'(newnote));
        run(150);

        // Randomized control and table traffic
        for (int i = 0; i < DEPTH; i++)
            wr(i, int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)));
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) start = 1'b1;
            if ($urandom_range(0, 39) == 0) stop = 1'b1;
            if ($urandom_range(0, 49) == 0) loop = ~loop;
            if ($urandom_range(0, 9) == 0) begin
                wr_en = 1'b1;
                wr_addr = AW'($urandom_range(0, DEPTH - 1));
                wr_note = 3'($urandom_range(0, 7));
                wr_dur = ($urandom_range(0, 7) == 0) ? '0 : DUR_W'($urandom_range(1, 3));
            end
            step();
        end

        // Asynchronous reset in the middle of a note
        loop = 1'b0; ena_mode = 0;
        wr(0, 6, 5);
        start = 1'b1;
        run(4);
        chk("pre_rst_f_ent", 32'(f_ent), 6);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_f_ent", 32'(f_ent), 0);
        chk("async_rst_playing", 32'(playing), 0);
        chk("async_rst_cur_idx", 32'(cur_idx), 0);
        chk("async_rst_done", 32'(done), 0);
        run(2);
        rst_n = 1'b1;
        start = 1'b1;
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
